// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath and its downstream MAC stages.
package booth_pkg;

    localparam int unsigned N_DEFAULT     = 32;
    localparam int unsigned GUARD_DEFAULT = 8;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    function automatic int unsigned acc_width(input int unsigned n, input int unsigned guard);
        return 2 * n + guard;
    endfunction

    localparam int unsigned ACC_W_DEFAULT = acc_width(N_DEFAULT, GUARD_DEFAULT);

    localparam logic [ACC_W_DEFAULT-1:0] ACC_MAX_DEFAULT = {1'b0, {(ACC_W_DEFAULT-1){1'b1}}};
    localparam logic [ACC_W_DEFAULT-1:0] ACC_MIN_DEFAULT = {1'b1, {(ACC_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/booth_product_accumulator_if.sv
// Product-in / result-out handshake bundle for the product accumulator.
interface booth_product_accumulator_if
    import booth_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned GUARD = GUARD_DEFAULT
);
    localparam int unsigned ACC_W = acc_width(N, GUARD);

    logic               in_valid;
    logic               in_ready;
    logic [2*N-1:0]     in_product;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [CNT_W-1:0]   out_count;
    logic               out_overflow;

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );

endinterface

// File: rtl/booth_sat_add.sv
// Combinational ACC_W signed adder with overflow detect and optional clamp.
module booth_sat_add #(
    parameter int unsigned ACC_W    = 72,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] res_o,
    output logic             ovf_o
);

    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] clamp;

    assign sum   = a_i + b_i;
    assign ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (sum[ACC_W-1] != a_i[ACC_W-1]);

    // On overflow both operands share a sign, which is also the sign of the true sum.
    assign clamp = a_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign res_o = (SATURATE && ovf_o) ? clamp : sum;

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums groups of signed Booth products (closed by in_last) into a guard-extended
// accumulator and presents one result per group with beat count and overflow flag.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned GUARD    = GUARD_DEFAULT,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    booth_product_accumulator_if.slave  bus
);

    localparam int unsigned ACC_W = acc_width(N, GUARD);
    localparam int unsigned PW    = 2 * N;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               oflow_q, oflow_d;

    logic               accept;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_res;
    logic               add_ovf;
    logic [ACC_W-1:0]   acc_beat;
    logic [CNT_W-1:0]   cnt_inc;

    assign prod_ext = {{GUARD{bus.in_product[PW-1]}}, bus.in_product};

    booth_sat_add #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .res_o (add_res),
        .ovf_o (add_ovf)
    );

    // Once a saturating group has clamped, further beats only advance the count.
    assign acc_beat = (SATURATE && ovf_q) ? acc_q : add_res;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    assign bus.in_ready     = (state_q != HOLD);
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.out_sum      = sum_q;
    assign bus.out_count    = count_q;
    assign bus.out_overflow = oflow_q;

    assign accept = bus.in_valid && (state_q != HOLD);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        count_d = count_q;
        oflow_d = oflow_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (bus.in_last) begin
                        state_d = HOLD;
                        sum_d   = acc_beat;
                        count_d = cnt_inc;
                        oflow_d = ovf_q | add_ovf;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ACCUM;
                        acc_d   = acc_beat;
                        cnt_d   = cnt_inc;
                        ovf_d   = ovf_q | add_ovf;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            oflow_q <= oflow_d;
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: one saturating and one wrapping accumulator share the same stimulus.
module tb_booth_product_accumulator;

    localparam logic [63:0] P_POS62 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] P_NEG62 = 64'hC000_0000_0000_0000;
    localparam logic [63:0] P_NEG63 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    always #5 clk = ~clk;

    booth_product_accumulator_if #(.N(32), .GUARD(8)) bus_s ();
    booth_product_accumulator_if #(.N(32), .GUARD(8)) bus_w ();

    assign bus_s.in_valid   = in_valid;
    assign bus_s.in_product = in_product;
    assign bus_s.in_last    = in_last;
    assign bus_s.out_ready  = out_ready;
    assign bus_w.in_valid   = in_valid;
    assign bus_w.in_product = in_product;
    assign bus_w.in_last    = in_last;
    assign bus_w.out_ready  = out_ready;

    booth_product_accumulator #(.N(32), .GUARD(8), .SATURATE(1'b1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    booth_product_accumulator #(.N(32), .GUARD(8), .SATURATE(1'b0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    // Present one beat and hold it until accepted; inputs change #1 after posedge.
    task automatic send_beat(input logic [63:0] p, input logic last);
        int unsigned budget;
        budget     = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        while (!bus_s.in_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus_s.in_ready) begin
            nvec++; nerr++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", bus_s.in_ready, budget);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        nvec++;
        if (bus_s.out_valid !== 1'b0) begin
            nerr++; $display("FAIL take_valid: out_valid=%0b required 0", bus_s.out_valid);
        end
        nvec++;
        if (bus_s.in_ready !== 1'b1) begin
            nerr++; $display("FAIL take_ready: in_ready=%0b required 1", bus_s.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nvec++;
        if (bus_s.in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_in_ready: got %0b required 1", bus_s.in_ready);
        end
        rst = 1'b0;
        nvec++;
        if (bus_s.out_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_out_valid: got %0b required 0", bus_s.out_valid);
        end
        nvec++;
        if (bus_s.out_sum !== 72'd0) begin
            nerr++; $display("FAIL reset_out_sum: got %h required 0", bus_s.out_sum);
        end
        nvec++;
        if (bus_s.out_count !== 16'd0) begin
            nerr++; $display("FAIL reset_out_count: got %0d required 0", bus_s.out_count);
        end
        nvec++;
        if (bus_s.out_overflow !== 1'b0) begin
            nerr++; $display("FAIL reset_out_overflow: got %0b required 0", bus_s.out_overflow);
        end
    endtask

    task automatic test_basic_group();
        send_beat(64'd3, 1'b0);
        nvec++;
        if (bus_s.out_valid !== 1'b0) begin
            nerr++; $display("FAIL basic_mid_valid: got %0b required 0", bus_s.out_valid);
        end
        send_beat(-64'sd5, 1'b0);
        send_beat(64'd7, 1'b1);
        nvec++;
        if (bus_s.out_valid !== 1'b1) begin
            nerr++; $display("FAIL basic_latency: out_valid=%0b required 1", bus_s.out_valid);
        end
        nvec++;
        if (bus_s.out_sum !== 72'd5) begin
            nerr++; $display("FAIL basic_sum: got %h required %h", bus_s.out_sum, 72'd5);
        end
        nvec++;
        if (bus_s.out_count !== 16'd3) begin
            nerr++; $display("FAIL basic_count: got %0d required 3", bus_s.out_count);
        end
        nvec++;
        if (bus_s.out_overflow !== 1'b0) begin
            nerr++; $display("FAIL basic_ovf: got %0b required 0", bus_s.out_overflow);
        end
        take_result();
    endtask

    task automatic test_single_beat();
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        nvec++;
        if (bus_s.out_sum !== {72{1'b1}}) begin
            nerr++; $display("FAIL single_sum: got %h required all ones", bus_s.out_sum);
        end
        nvec++;
        if (bus_s.out_count !== 16'd1) begin
            nerr++; $display("FAIL single_count: got %0d required 1", bus_s.out_count);
        end
        take_result();
    endtask

    // 600 * 2^62 exceeds 2^71-1 at beat 512; wrapped value is (600-1024)*2^62.
    task automatic test_saturate_positive();
        logic [71:0] exp_sat;
        logic [71:0] exp_wrap;
        exp_sat  = {1'b0, {71{1'b1}}};
        exp_wrap = 72'd0 - (72'd424 << 62);
        for (int i = 0; i < 599; i++) send_beat(P_POS62, 1'b0);
        send_beat(P_POS62, 1'b1);
        nvec++;
        if (bus_s.out_sum !== exp_sat) begin
            nerr++; $display("FAIL satpos_sum: got %h required %h", bus_s.out_sum, exp_sat);
        end
        nvec++;
        if (bus_s.out_overflow !== 1'b1) begin
            nerr++; $display("FAIL satpos_ovf: got %0b required 1", bus_s.out_overflow);
        end
        nvec++;
        if (bus_s.out_count !== 16'd600) begin
            nerr++; $display("FAIL satpos_count: got %0d required 600", bus_s.out_count);
        end
        nvec++;
        if (bus_w.out_sum !== exp_wrap) begin
            nerr++; $display("FAIL wrappos_sum: got %h required %h", bus_w.out_sum, exp_wrap);
        end
        nvec++;
        if (bus_w.out_overflow !== 1'b1) begin
            nerr++; $display("FAIL wrappos_ovf: got %0b required 1", bus_w.out_overflow);
        end
        take_result();
    endtask

    // 300 * -2^63 = -600*2^62 passes -2^71; wrapped value is 424*2^62.
    task automatic test_saturate_negative();
        logic [71:0] exp_sat;
        logic [71:0] exp_wrap;
        exp_sat  = {1'b1, {71{1'b0}}};
        exp_wrap = 72'd424 << 62;
        for (int i = 0; i < 299; i++) send_beat(P_NEG63, 1'b0);
        send_beat(P_NEG63, 1'b1);
        nvec++;
        if (bus_s.out_sum !== exp_sat) begin
            nerr++; $display("FAIL satneg_sum: got %h required %h", bus_s.out_sum, exp_sat);
        end
        nvec++;
        if (bus_w.out_sum !== exp_wrap) begin
            nerr++; $display("FAIL wrapneg_sum: got %h required %h", bus_w.out_sum, exp_wrap);
        end
        nvec++;
        if (bus_w.out_overflow !== 1'b1) begin
            nerr++; $display("FAIL wrapneg_ovf: got %0b required 1", bus_w.out_overflow);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        send_beat(64'd1, 1'b1);
        in_valid   = 1'b1;
        in_product = 64'd9;
        in_last    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (bus_s.in_ready !== 1'b0) begin
                nerr++; $display("FAIL bp_ready cyc%0d: got %0b required 0", i, bus_s.in_ready);
            end
            nvec++;
            if (bus_s.out_valid !== 1'b1 || bus_s.out_sum !== 72'd1) begin
                nerr++; $display("FAIL bp_hold cyc%0d: valid=%0b sum=%h required 1/%h", i, bus_s.out_valid, bus_s.out_sum, 72'd1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        nvec++;
        if (bus_s.in_ready !== 1'b1 || bus_s.out_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0", bus_s.in_ready, bus_s.out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        send_beat(64'd0, 1'b1);
        nvec++;
        if (bus_s.out_sum !== 72'd9 || bus_s.out_count !== 16'd2) begin
            nerr++; $display("FAIL bp_next_group: sum=%h count=%0d required %h/2", bus_s.out_sum, bus_s.out_count, 72'd9);
        end
        take_result();
    endtask

    task automatic test_reset_mid_group();
        send_beat(64'd100, 1'b0);
        send_beat(64'd200, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvec++;
        if (bus_s.in_ready !== 1'b1 || bus_s.out_valid !== 1'b0) begin
            nerr++; $display("FAIL rstmid_state: in_ready=%0b out_valid=%0b required 1/0", bus_s.in_ready, bus_s.out_valid);
        end
        send_beat(64'd10, 1'b1);
        nvec++;
        if (bus_s.out_sum !== 72'd10 || bus_s.out_count !== 16'd1) begin
            nerr++; $display("FAIL rstmid_result: sum=%h count=%0d required %h/1", bus_s.out_sum, bus_s.out_count, 72'd10);
        end
        take_result();
    endtask

    task automatic test_corner_product();
        send_beat(P_POS62, 1'b0);
        send_beat(P_NEG62, 1'b1);
        nvec++;
        if (bus_s.out_sum !== 72'd0 || bus_s.out_overflow !== 1'b0) begin
            nerr++; $display("FAIL corner: sum=%h ovf=%0b required 0/0", bus_s.out_sum, bus_s.out_overflow);
        end
        nvec++;
        if (bus_w.out_sum !== 72'd0 || bus_w.out_overflow !== 1'b0) begin
            nerr++; $display("FAIL corner_wrap: sum=%h ovf=%0b required 0/0", bus_w.out_sum, bus_w.out_overflow);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        send_beat(64'd4, 1'b1);
        take_result();
        send_beat(-64'sd6, 1'b1);
        nvec++;
        if (bus_s.out_sum !== (72'd0 - 72'd6) || bus_s.out_count !== 16'd1) begin
            nerr++; $display("FAIL b2b: sum=%h count=%0d required %h/1", bus_s.out_sum, bus_s.out_count, 72'd0 - 72'd6);
        end
        take_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic_group();
        test_single_beat();
        test_saturate_positive();
        test_saturate_negative();
        test_backpressure();
        test_reset_mid_group();
        test_corner_product();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
